// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : booth_multiplier
// Purpose : Sequential radix-2 Booth multiplier for two's-complement operands.
//           One Booth step per clock; the result is registered and flagged by
//           a one-cycle done pulse n+1 edges after the accepting start edge.
// Ports   :
//   clk     in  1     rising-edge clock
//   rst     in  1     asynchronous active-high reset
//   start   in  1     begin a multiply (honoured only while idle)
//   a       in  n     multiplicand (signed)
//   b       in  n     multiplier (signed)
//   product out 2n    registered signed product a*b
//   busy    out 1     high in RUN and FINISH
//   done    out 1     one-cycle pulse coinciding with a product update
// Revision: 1.0 - initial release
// ============================================================================
module booth_multiplier #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] product,
  output logic           busy,
  output logic           done
);

  // Counter must hold the value n itself.
  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [n:0]       acc_q,   acc_d;    // A: one guard bit so -2^(n-1) cannot overflow
  logic [n:0]       m_q,     m_d;      // M: sign-extended multiplicand
  logic [n-1:0]     q_q,     q_d;      // Q: multiplier, shifts out as product bits shift in
  logic             qm1_q,   qm1_d;    // Q-1
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [2*n-1:0]   prod_q,  prod_d;
  logic             done_q,  done_d;

  // Single adder/subtractor: subtract is A + ~M + 1.
  logic             sub_mode;
  logic [n:0]       addend;
  logic [n:0]       addsub_res;
  logic [n:0]       acc_sel;

  always_comb begin
    sub_mode   = q_q[0] & ~qm1_q;                       // pair 10 -> A - M
    addend     = sub_mode ? ~m_q : m_q;
    addsub_res = acc_q + addend + {{n{1'b0}}, sub_mode};
    // Pairs 00 and 11 leave A untouched.
    acc_sel    = (q_q[0] ^ qm1_q) ? addsub_res : acc_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {a[n-1], a};
          q_d     = b;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(n);
          state_d = RUN;
        end
      end

      RUN: begin
        // Arithmetic shift right of {A,Q,Q-1}, replicating the sign of A.
        acc_d = {acc_sel[n], acc_sel[n:1]};
        q_d   = {acc_sel[0], q_q[n-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        // Guard bit of A is a redundant sign copy at this point.
        prod_d  = {acc_q[n-1:0], q_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign product = prod_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth_multiplier
// Purpose : Self-checking bench for booth_multiplier (n = 8): directed
//           vectors, start-while-busy, back-to-back, reset abort and a
//           random sweep against a signed reference multiply.
// Revision: 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int n_vec = 0;
  int n_bad = 0;

  booth_multiplier #(.n(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and wait for its done pulse; checks latency, result,
  // busy behaviour and that done is a single-cycle pulse.
  task automatic run_op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [2*N-1:0] exp, input bit full);
    int cyc;
    bit got;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (full) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
      if (full) begin
        chk({tag, "_lat"}, cyc, N + 1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      end
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin : main
    int cyc;
    int pulses;
    int pcyc;
    int first_done;
    int second_done;
    logic [2*N-1:0] pval;
    logic signed [N-1:0]   ra;
    logic signed [N-1:0]   rb;
    logic signed [2*N-1:0] rexp;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run_op("p3x5",   8'd3,   8'd5,   16'h000F, 1'b1);
    run_op("m3x5",   8'hFD,  8'd5,   16'hFFF1, 1'b1);
    run_op("m3xm5",  8'hFD,  8'hFB,  16'h000F, 1'b1);
    run_op("minmin", 8'h80,  8'h80,  16'h4000, 1'b1);
    run_op("minmax", 8'h80,  8'h7F,  16'hC080, 1'b1);
    run_op("zero",   8'h00,  8'hA5,  16'h0000, 1'b1);
    run_op("maxmax", 8'h7F,  8'h7F,  16'h3F01, 1'b1);
    run_op("m1xm1",  8'hFF,  8'hFF,  16'h0001, 1'b1);

    // Start pulsed at cycle 3 with new operands must be ignored.
    @(negedge clk);
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    pcyc = 0;
    pval = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end
      if (c == 3) start = 1'b0;
      if (done) begin
        pulses++;
        pcyc = c;
        pval = product;
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_lat", pcyc, N + 1);
    chk("ign_prod", {16'd0, pval}, 32'h0000_000F);

    // Back-to-back with start held high: results every n+2 cycles.
    @(negedge clk);
    a = 8'd2;
    b = 8'hFD;
    start = 1'b1;
    cyc = 0;
    first_done = -1;
    second_done = -1;
    while (second_done < 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        if (first_done < 0) begin
          first_done = cyc;
          chk("b2b_prod1", {16'd0, product}, 32'h0000_FFFA);
        end else begin
          second_done = cyc;
          chk("b2b_prod2", {16'd0, product}, 32'h0000_FFFA);
        end
      end
    end
    start = 1'b0;
    chk("b2b_period", second_done - first_done, N + 2);
    for (int c = 0; c < 12 && busy; c++) @(posedge clk);
    #1;

    // Reset in RUN after step 4 aborts the operation.
    @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_prod", {16'd0, product}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_nopulse", pulses, 0);
    run_op("p7xm2", 8'd7, 8'hFE, 16'hFFF2, 1'b1);

    // Random sweep against the signed reference.
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rexp = 16'(ra * rb);
      rexp = $signed({{N{ra[N-1]}}, ra}) * $signed({{N{rb[N-1]}}, rb});
      run_op("rand", ra, rb, rexp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the operand width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin a multiply; sampled on clk rising edges.
REQ-005 Port a, input, n bits: two's-complement multiplicand.
REQ-006 Port b, input, n bits: two's-complement multiplier.
REQ-007 Port product, output, 2n bits: registered two's-complement result a*b.
REQ-008 Port busy, output, 1 bit: high while a multiply is in progress or completing.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking that product has just updated.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and FINISH.
REQ-011 In IDLE with start=1 on a rising edge, the block SHALL latch a into M and b into Q, clear A and Q-1, set the step counter to n, and enter RUN.
REQ-012 A SHALL be n+1 bits wide, and M SHALL be sign-extended to n+1 bits, so that a = -2^(n-1) cannot overflow.
REQ-013 Each RUN cycle SHALL examine {Q[0],Q-1}:
  - 01: A = A+M.
  - 10: A = A-M.
  - 00 or 11: A unchanged.
  - The adder/subtractor result SHALL come from a single add/subtract path with a mode bit.
REQ-014 In the same cycle, the block SHALL arithmetic-shift-right {A,Q,Q-1} by one (sign of A preserved) and decrement the counter.
REQ-015 On the RUN step where the counter equals 1, the block SHALL move to FINISH.
REQ-016 In FINISH, the block SHALL load product with the low 2n bits of {A,Q}, assert done for exactly that one cycle, and return to IDLE.
REQ-017 Latency: with start sampled at edge k, product and done SHALL become valid after edge k+n+1; done SHALL be high for exactly one clock.
REQ-018 busy SHALL be high in RUN and FINISH and low in IDLE.
REQ-019 start SHALL be ignored while busy=1; a, b and product SHALL NOT be disturbed by it.
REQ-020 Changes on a and b after the start edge SHALL NOT affect the operation in flight.
REQ-021 product SHALL hold its last value until the next FINISH.
REQ-022 With start held high continuously, a new operation SHALL begin on the first IDLE edge, giving back-to-back results every n+2 cycles.
REQ-023 The result SHALL be exact for all 2^(2n) operand pairs, including both operands equal to -2^(n-1).

Reset
REQ-024 On rst=1, the block SHALL immediately (asynchronously) enter IDLE and clear A, Q, Q-1, M, counter and product, with busy=0 and done=0.
REQ-025 Reset during RUN or FINISH SHALL abort the operation and SHALL produce no done pulse.
REQ-026 After rst falls, the first start SHALL be accepted on the next rising edge.

Verification (n=8)
REQ-027 a=3, b=5, pulse start -> done exactly 9 cycles after the start edge; product=16'h000F.
REQ-028 a=-3 (8'hFD), b=5 -> product=16'hFFF1 (-15); a=-3, b=-5 -> product=16'h000F.
REQ-029 a=8'h80, b=8'h80 -> product=16'h4000; a=8'h80, b=8'h7F -> product=16'hC080.
REQ-030 Pulse start again at cycle 3 of an operation with different a and b -> ignored; the original result appears once with a single done pulse.
REQ-031 Assert rst during RUN at step 4 -> busy=0 and product=0 immediately, no done pulse; a following start with a=7, b=-2 -> product=16'hFFF2.
REQ-032 Random self-check: 1000 random operand pairs compared against a signed reference multiply; every result exact and every done pulse one cycle wide.
